bidir_shift_sequencer: RTL and testbench
========================================

Name: bidir_shift_sequencer

Overview:
Upstream command sequencer for the 4-bit bidirectional shift register stage. It accepts one parallel word, a direction and a shift count over a valid/ready handshake. It then drives the register's mode and serial inputs (Dr/Dl) one bit per clock for the commanded number of cycles. It flags each meaningful shift cycle and signals completion.

Parameters:
WIDTH, 4, width of the downstream shift register and of cmd_data.
CNT_W, 3, width of cmd_count; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command (high only in IDLE)
cmd_dir  input  1  1 = right shift (mode=1, data on dr); 0 = left shift (mode=0, data on dl)
cmd_count  input  CNT_W  number of shifts; values above WIDTH are clamped to WIDTH
cmd_data  input  WIDTH  bits to serialise
abort  input  1  synchronous cancel of an in-progress command
mode  output  1  direction select to the shift register
dr  output  1  right-shift serial data
dl  output  1  left-shift serial data
shift_en  output  1  high in each cycle whose mode/dr/dl is a commanded shift
busy  output  1  high in SHIFT or DONE
done  output  1  one-cycle completion pulse

Behaviour:
- All outputs are registered. The reset is asynchronous and active-high, and it forces the following: state=IDLE, cmd_ready=1, mode=0, dr=0, dl=0, shift_en=0, busy=0, done=0.
- States: IDLE, SHIFT, DONE.
- IDLE: cmd_ready=1, shift_en=0, dr=dl=0, and mode holds its last value. A command is accepted at an edge where cmd_valid && cmd_ready.
  - The accept edge latches cmd_data, cmd_dir and the clamped count n.
  - If n=0, go to DONE.
  - Otherwise go to SHIFT, and drive the first bit in the following cycle.
- SHIFT: each cycle drives mode=cmd_dir, shift_en=1 and one data bit. The inactive serial line is held at 0.
  - Right (dir=1): dr carries data[0], data[1], …, data[n-1] in order. After n downstream shifts, q[WIDTH-1 -: n] = data[n-1:0]. For n=WIDTH, q = data.
  - Left (dir=0): dl carries data[n-1], data[n-2], …, data[0] in order. After n downstream shifts, q[n-1:0] = data[n-1:0]. For n=WIDTH, q = data.
  - shift_en is high for exactly n consecutive cycles. The downstream register samples the bits at the n edges that end those cycles.
  - After the n-th cycle, go to DONE.
- DONE: lasts one cycle with done=1, shift_en=0, dr=dl=0 and cmd_ready=0. It then returns to IDLE, where cmd_ready=1 in the next cycle.
- Latency: a command accepted at edge k completes with done high in cycle k+n+1. The next command can be accepted at edge k+n+2 at the earliest.
- busy=1 in SHIFT and DONE, and 0 in IDLE.
- Internal counter: CNT_W bits, counts down from n to 0 and never wraps. The bit index uses the same counter, with no separate shifter wider than WIDTH.
- abort in SHIFT:
  - The next cycle is IDLE with shift_en=0 and dr=dl=0.
  - done is not pulsed.
  - mode holds its last value.
- abort in IDLE or DONE is ignored. abort takes priority over count completion in the same cycle.
- cmd_valid while cmd_ready=0 is ignored, and cmd_data may change freely during that time.
- Reset asserted mid-operation returns to the reset values immediately, independent of clk.

Test Plan:
- Reset then release: all outputs at reset values with cmd_ready=1. Holding cmd_valid=0 for 5 cycles leaves shift_en=0 throughout.
- Right, full load: dir=1, count=4, data=4'b1011 → dr=1,1,0,1 over 4 cycles with shift_en=1 and mode=1; done is pulsed in cycle 5; downstream q=4'b1011.
- Left, partial: dir=0, count=2, data=4'b0010 → dl=1,0; shift_en high for 2 cycles, then done; downstream q[1:0]=2'b10.
- Clamp and zero: count=7 behaves as count=4 (4 shift_en cycles). count=0 gives no shift_en and done one cycle after accept.
- Abort: abort in the 2nd SHIFT cycle of a count=4 command → shift_en drops the next cycle, done is never pulsed, cmd_ready=1; a following command executes normally.
- Async reset during SHIFT: outputs are at reset values before the next clk edge, and cmd_valid is ignored while cmd_ready=0 in the DONE cycle.

Source files
------------

// File: rtl/bidir_shift_sequencer.sv
// Command sequencer for the bidirectional shift register stage.
// Accepts one parallel word, a direction and a shift count over valid/ready,
// then serialises the word onto dr or dl one bit per clock. It flags every
// commanded shift cycle and pulses done at the end. All outputs are registered.
module bidir_shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic             mode,
  output logic             dr,
  output logic             dl,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LP_WIDTH = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_n;
  logic [WIDTH-1:0] r_data;
  logic             r_dir;
  logic             r_mode;
  logic             r_dr;
  logic             r_dl;
  logic             r_shiftEn;
  logic             r_busy;
  logic             r_done;
  logic             r_ready;

  state_t           w_stateNext;
  logic [CNT_W-1:0] w_cntNext;
  logic [CNT_W-1:0] w_nNext;
  logic [WIDTH-1:0] w_dataNext;
  logic             w_dirNext;
  logic             w_modeNext;
  logic             w_drNext;
  logic             w_dlNext;
  logic             w_shiftEnNext;
  logic             w_busyNext;
  logic             w_doneNext;
  logic             w_readyNext;
  logic [CNT_W-1:0] w_clamped;
  logic [CNT_W-1:0] w_bitIdx;
  logic [WIDTH-1:0] w_srcData;
  logic [WIDTH-1:0] w_shifted;
  logic             w_srcDir;
  logic             w_drive;
  logic             w_bit;

  // Counts above the register width would shift out data already placed, so cap them.
  assign w_clamped = (cmd_count > LP_WIDTH) ? LP_WIDTH : cmd_count;

  // Next-state and next-output logic; the counter holds the shifts still owed, including the one being driven.
  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt;
    w_nNext       = r_n;
    w_dataNext    = r_data;
    w_dirNext     = r_dir;
    w_modeNext    = r_mode;
    w_shiftEnNext = 1'b0;
    w_busyNext    = 1'b0;
    w_doneNext    = 1'b0;
    w_readyNext   = 1'b0;
    w_bitIdx      = '0;
    w_srcData     = r_data;
    w_srcDir      = r_dir;
    w_drive       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_readyNext = 1'b1;
        if (cmd_valid) begin
          w_dataNext  = cmd_data;
          w_dirNext   = cmd_dir;
          w_nNext     = w_clamped;
          w_cntNext   = w_clamped;
          w_readyNext = 1'b0;
          w_busyNext  = 1'b1;
          if (w_clamped == '0) begin
            w_stateNext = ST_DONE;
            w_doneNext  = 1'b1;
          end else begin
            w_stateNext   = ST_SHIFT;
            w_shiftEnNext = 1'b1;
            w_modeNext    = cmd_dir;
            w_drive       = 1'b1;
            w_srcData     = cmd_data;
            w_srcDir      = cmd_dir;
            w_bitIdx      = cmd_dir ? '0 : (w_clamped - LP_ONE);
          end
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
          w_readyNext = 1'b1;
        end else if (r_cnt == LP_ONE) begin
          w_stateNext = ST_DONE;
          w_cntNext   = '0;
          w_doneNext  = 1'b1;
          w_busyNext  = 1'b1;
        end else begin
          w_cntNext     = r_cnt - LP_ONE;
          w_busyNext    = 1'b1;
          w_shiftEnNext = 1'b1;
          w_modeNext    = r_dir;
          w_drive       = 1'b1;
          w_bitIdx      = r_dir ? (r_n - w_cntNext) : (w_cntNext - LP_ONE);
        end
      end
      ST_DONE: begin
        w_stateNext = ST_IDLE;
        w_readyNext = 1'b1;
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_readyNext = 1'b1;
      end
    endcase
    w_shifted = w_srcData >> w_bitIdx;
    w_bit     = w_drive & w_shifted[0];
    w_drNext  = w_bit & w_srcDir;
    w_dlNext  = w_bit & ~w_srcDir;
  end

  // State, command latch and registered outputs; reset forces the idle/ready picture at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_n       <= '0;
      r_data    <= '0;
      r_dir     <= 1'b0;
      r_mode    <= 1'b0;
      r_dr      <= 1'b0;
      r_dl      <= 1'b0;
      r_shiftEn <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_n       <= w_nNext;
      r_data    <= w_dataNext;
      r_dir     <= w_dirNext;
      r_mode    <= w_modeNext;
      r_dr      <= w_drNext;
      r_dl      <= w_dlNext;
      r_shiftEn <= w_shiftEnNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
      r_ready   <= w_readyNext;
    end
  end

  assign cmd_ready = r_ready;
  assign mode      = r_mode;
  assign dr        = r_dr;
  assign dl        = r_dl;
  assign shift_en  = r_shiftEn;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_bidir_shift_sequencer.sv
// Testbench for bidir_shift_sequencer: a vector table of commands with
// hand-computed serial streams and downstream register contents, plus
// hand-written sequences for abort, async reset and the DONE-cycle handshake.
module tb_bidir_shift_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [2:0] cmd_count;
  logic [3:0] cmd_data;
  logic       abort;
  logic       mode;
  logic       dr;
  logic       dl;
  logic       shift_en;
  logic       busy;
  logic       done;

  logic [3:0] q;
  int         checkCount;
  int         errorCount;

  typedef struct {
    logic       dir;
    logic [2:0] count;
    logic [3:0] data;
    int         expN;
    logic [3:0] expStream;
    logic [3:0] qMask;
    logic [3:0] qExp;
  } vec_t;

  vec_t vecs[9];

  bidir_shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_count (cmd_count),
    .cmd_data  (cmd_data),
    .abort     (abort),
    .mode      (mode),
    .dr        (dr),
    .dl        (dl),
    .shift_en  (shift_en),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 4-bit shift register: right shift feeds dr into the MSB, left shift feeds dl into the LSB.
  always @(posedge clk or posedge rst) begin
    if (rst) q <= 4'b0000;
    else if (shift_en) q <= mode ? {dr, q[3:1]} : {q[2:0], dl};
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Called at a falling edge in IDLE; presents the command for one accept edge, then scrambles the inputs.
  task automatic applyStimulus(input logic dir, input logic [2:0] count, input logic [3:0] data);
    checkOutput("ready_before_accept", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_count = count;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = ~data;
    cmd_count = 3'd5;
  endtask

  task automatic runVector(input vec_t v);
    int   shiftCount;
    int   doneCycle;
    logic activeLine;
    logic idleLine;
    shiftCount = 0;
    doneCycle  = 0;
    applyStimulus(v.dir, v.count, v.data);
    for (int c = 1; c <= 12 && doneCycle == 0; c++) begin
      @(negedge clk);
      checkOutput("busy_during_cmd", {31'b0, busy}, 32'd1);
      checkOutput("ready_during_cmd", {31'b0, cmd_ready}, 32'd0);
      if (shift_en) begin
        activeLine = v.dir ? dr : dl;
        idleLine   = v.dir ? dl : dr;
        checkOutput("shift_mode", {31'b0, mode}, {31'b0, v.dir});
        if (shiftCount < 4)
          checkOutput("serial_bit", {31'b0, activeLine}, {31'b0, v.expStream[shiftCount]});
        checkOutput("inactive_line", {31'b0, idleLine}, 32'd0);
        shiftCount++;
      end
      if (done) begin
        doneCycle = c;
        checkOutput("done_shift_en", {31'b0, shift_en}, 32'd0);
        checkOutput("done_lines", {30'b0, dr, dl}, 32'd0);
      end
    end
    checkOutput("shift_cycles", shiftCount, v.expN);
    checkOutput("done_cycle", doneCycle, v.expN + 1);
    @(negedge clk);
    checkOutput("idle_ready", {31'b0, cmd_ready}, 32'd1);
    checkOutput("idle_busy", {31'b0, busy}, 32'd0);
    checkOutput("idle_done", {31'b0, done}, 32'd0);
    checkOutput("idle_shift_en", {31'b0, shift_en}, 32'd0);
    checkOutput("downstream_q", {28'b0, q & v.qMask}, {28'b0, v.qExp});
    if (v.expN > 0)
      checkOutput("idle_mode_hold", {31'b0, mode}, {31'b0, v.dir});
  endtask

  initial begin
    logic doneSeen;
    checkCount = 0;
    errorCount = 0;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'b0;
    cmd_count  = 3'd0;
    cmd_data   = 4'b0000;
    abort      = 1'b0;

    //                dir   count  data     n  stream   qMask    qExp
    vecs[0] = '{1'b1, 3'd4, 4'b1011, 4, 4'b1011, 4'b1111, 4'b1011};
    vecs[1] = '{1'b0, 3'd2, 4'b0010, 2, 4'b0001, 4'b0011, 4'b0010};
    vecs[2] = '{1'b1, 3'd7, 4'b0110, 4, 4'b0110, 4'b1111, 4'b0110};
    vecs[3] = '{1'b0, 3'd0, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000};
    vecs[4] = '{1'b0, 3'd4, 4'b1001, 4, 4'b1001, 4'b1111, 4'b1001};
    vecs[5] = '{1'b1, 3'd3, 4'b0101, 3, 4'b0101, 4'b1110, 4'b1010};
    vecs[6] = '{1'b0, 3'd5, 4'b1100, 4, 4'b0011, 4'b1111, 4'b1100};
    vecs[7] = '{1'b1, 3'd1, 4'b1110, 1, 4'b0000, 4'b1000, 4'b0000};
    vecs[8] = '{1'b0, 3'd1, 4'b0001, 1, 4'b0001, 4'b0001, 4'b0001};

    #2;
    checkOutput("reset_ready", {31'b0, cmd_ready}, 32'd1);
    checkOutput("reset_outputs", {27'b0, mode, dr, dl, shift_en, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("quiet_shift_en", {31'b0, shift_en}, 32'd0);
      checkOutput("quiet_ready", {31'b0, cmd_ready}, 32'd1);
    end

    $display("[TB] running vector table");
    for (int i = 0; i < 9; i++) runVector(vecs[i]);

    $display("[TB] abort in second shift cycle");
    applyStimulus(1'b1, 3'd4, 4'b1111);
    @(negedge clk);
    checkOutput("abort_cycle1_shift_en", {31'b0, shift_en}, 32'd1);
    @(negedge clk);
    checkOutput("abort_cycle2_shift_en", {31'b0, shift_en}, 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_shift_en", {31'b0, shift_en}, 32'd0);
    checkOutput("abort_ready", {31'b0, cmd_ready}, 32'd1);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_lines", {30'b0, dr, dl}, 32'd0);
    checkOutput("abort_mode_hold", {31'b0, mode}, 32'd1);
    doneSeen = done;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      doneSeen = doneSeen | done;
    end
    checkOutput("abort_no_done", {31'b0, doneSeen}, 32'd0);
    runVector(vecs[1]);

    $display("[TB] async reset during shift");
    applyStimulus(1'b1, 3'd4, 4'b1111);
    @(negedge clk);
    checkOutput("pre_reset_shift_en", {31'b0, shift_en}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_ready", {31'b0, cmd_ready}, 32'd1);
    checkOutput("async_reset_outputs", {27'b0, mode, dr, dl, shift_en, busy}, 32'd0);
    checkOutput("async_reset_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_idle", {29'b0, cmd_ready, shift_en, busy}, 32'd4);

    $display("[TB] cmd_valid held through DONE cycle");
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_count = 3'd0;
    cmd_data  = 4'b0000;
    @(posedge clk);
    #1;
    cmd_count = 3'd4;
    cmd_data  = 4'b1111;
    @(negedge clk);
    checkOutput("zero_done", {31'b0, done}, 32'd1);
    checkOutput("zero_done_ready", {31'b0, cmd_ready}, 32'd0);
    checkOutput("zero_done_busy", {31'b0, busy}, 32'd1);
    checkOutput("zero_done_shift_en", {31'b0, shift_en}, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("after_done_ready", {31'b0, cmd_ready}, 32'd1);
    checkOutput("after_done_shift_en", {31'b0, shift_en}, 32'd0);
    checkOutput("after_done_busy", {31'b0, busy}, 32'd0);
    checkOutput("after_done_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    checkOutput("still_idle_shift_en", {31'b0, shift_en}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
